// File: rtl/ti_sbox_seq_pkg.sv
// -----------------------------------------------------------------------------
// ti_sbox_pkg
// Shared definitions for the byte-serial TI S-box sequencer:
//   - state_t      : sequencer phase (LOAD / RUN / UNLOAD)
//   - DEF_*        : default share count, randomness bytes and core latency
//   - ctr_width()  : width of a counter that must index n distinct values
// -----------------------------------------------------------------------------
package ti_sbox_pkg;

   typedef enum logic [1:0] {
      S_LOAD   = 2'd0,
      S_RUN    = 2'd1,
      S_UNLOAD = 2'd2
   } state_t;

   localparam int DEF_NSHARES   = 3;
   localparam int DEF_RND_BYTES = 4;
   localparam int DEF_LATENCY   = 4;

   // clog2(n), but never narrower than one bit so that degenerate
   // parameterisations still elaborate.
   function automatic int ctr_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ti_sbox_seq_buf.sv
// -----------------------------------------------------------------------------
// ti_sbox_seq_buf
// Byte-addressed register bank holding the input shares, the fresh
// randomness and the captured output shares of one S-box evaluation.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear of every byte in the bank
//   wr_en       : write wr_data into slot wr_idx
//                 (slots 0..NSHARES-1 = input shares,
//                  slots NSHARES..NSHARES+RND_BYTES-1 = random bytes)
//   wr_idx      : write slot
//   wr_data     : write byte
//   ld_en       : bulk load of the output buffer from ld_data
//   ld_data     : output shares from the core, share i at [8i+7:8i]
//   rd_idx      : output-buffer share to read
//   rd_data     : output-buffer byte rd_idx (0 when rd_idx is out of range)
//   x_flat      : input shares, share i at [8i+7:8i]
//   r_flat      : random bytes, byte j at [8j+7:8j]
//
// Every byte lives in its own register with its own enable, so no logic
// in this bank ever mixes the contents of two shares.
// -----------------------------------------------------------------------------
module ti_sbox_seq_buf
   import ti_sbox_pkg::*;
#(
   parameter int NSHARES   = DEF_NSHARES,
   parameter int RND_BYTES = DEF_RND_BYTES,
   parameter int IDX_W     = ctr_width(NSHARES + RND_BYTES)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   wr_en,
   input  logic [IDX_W-1:0]       wr_idx,
   input  logic [7:0]             wr_data,
   input  logic                   ld_en,
   input  logic [NSHARES*8-1:0]   ld_data,
   input  logic [IDX_W-1:0]       rd_idx,
   output logic [7:0]             rd_data,
   output logic [NSHARES*8-1:0]   x_flat,
   output logic [RND_BYTES*8-1:0] r_flat
);

   logic [NSHARES*8-1:0] y_flat;

   genvar gi;

   // Input shares: slots 0..NSHARES-1.
   generate
      for (gi = 0; gi < NSHARES; gi++) begin : g_x
         logic [7:0] x_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               x_reg <= '0;
            end else if (clr) begin
               x_reg <= '0;
            end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
               x_reg <= wr_data;
            end
         end
         assign x_flat[gi*8 +: 8] = x_reg;
      end
   endgenerate

   // Random bytes: slots NSHARES..NSHARES+RND_BYTES-1.
   generate
      for (gi = 0; gi < RND_BYTES; gi++) begin : g_r
         logic [7:0] r_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_reg <= '0;
            end else if (clr) begin
               r_reg <= '0;
            end else if (wr_en && (wr_idx == IDX_W'(NSHARES + gi))) begin
               r_reg <= wr_data;
            end
         end
         assign r_flat[gi*8 +: 8] = r_reg;
      end
   endgenerate

   // Output shares: loaded all at once from the core.
   generate
      for (gi = 0; gi < NSHARES; gi++) begin : g_y
         logic [7:0] y_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               y_reg <= '0;
            end else if (clr) begin
               y_reg <= '0;
            end else if (ld_en) begin
               y_reg <= ld_data[gi*8 +: 8];
            end
         end
         assign y_flat[gi*8 +: 8] = y_reg;
      end
   endgenerate

   // Read port over the output buffer only; the consumer registers it.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NSHARES; i++) begin
         if (rd_idx == IDX_W'(i)) begin
            rd_data = y_flat[i*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/ti_sbox_seq.sv
// -----------------------------------------------------------------------------
// ti_sbox_seq
// Byte-serial sequencer for a threshold-implementation AES S-box core.
// Collects NSHARES input shares and RND_BYTES random bytes one byte per
// handshake, runs the fixed-latency masked core for LATENCY enabled cycles,
// captures the output shares and returns them one byte per handshake.
// Shares are only ever moved, never combined.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   ena          : tile enable; low freezes all state and hides ready/valid
//   flush        : synchronous abort back to LOAD, clearing all buffers
//   din          : input byte (shares first, then random bytes)
//   din_valid    : din valid
//   din_ready    : din accepted this cycle (LOAD phase)
//   dout         : output share byte (share 0 first), registered
//   dout_valid   : dout valid (UNLOAD phase)
//   dout_ready   : consumer accepts dout
//   sbox_x       : input shares to the core, share i at [8i+7:8i]
//   sbox_r       : randomness to the core, byte j at [8j+7:8j]
//   sbox_en      : core pipeline advance enable
//   sbox_y       : output shares from the core
//   busy         : high in RUN and UNLOAD
//   done         : one-cycle pulse after the last output byte is accepted
// -----------------------------------------------------------------------------
module ti_sbox_seq
   import ti_sbox_pkg::*;
#(
   parameter int NSHARES   = DEF_NSHARES,
   parameter int RND_BYTES = DEF_RND_BYTES,
   parameter int LATENCY   = DEF_LATENCY
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ena,
   input  logic                   flush,
   input  logic [7:0]             din,
   input  logic                   din_valid,
   output logic                   din_ready,
   output logic [7:0]             dout,
   output logic                   dout_valid,
   input  logic                   dout_ready,
   output logic [NSHARES*8-1:0]   sbox_x,
   output logic [RND_BYTES*8-1:0] sbox_r,
   output logic                   sbox_en,
   input  logic [NSHARES*8-1:0]   sbox_y,
   output logic                   busy,
   output logic                   done
);

   localparam int NSLOTS = NSHARES + RND_BYTES;
   localparam int IDX_W  = ctr_width(NSLOTS);
   localparam int CNT_W  = ctr_width(LATENCY + 1);

   localparam logic [IDX_W-1:0] LAST_SLOT  = IDX_W'(NSLOTS - 1);
   localparam logic [IDX_W-1:0] LAST_SHARE = IDX_W'(NSHARES - 1);
   localparam logic [CNT_W-1:0] CNT_CAP    = CNT_W'(LATENCY);

   state_t           state_reg;
   logic [IDX_W-1:0] idx_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [7:0]       dout_reg;
   logic             done_reg;

   logic             in_hs;
   logic             out_hs;
   logic             out_last;
   logic             capture;
   logic             buf_clr;
   logic [IDX_W-1:0] rd_idx;
   logic [7:0]       rd_data;

   // ------------------------------------------------------------------
   // Handshake / control decode. Flush wins over everything except reset,
   // so a handshake in the flush cycle never reaches the state or buffers.
   // ------------------------------------------------------------------
   assign din_ready  = ena && (state_reg == S_LOAD);
   assign dout_valid = ena && (state_reg == S_UNLOAD);

   assign in_hs    = !flush && din_valid && din_ready;
   assign out_hs   = !flush && dout_valid && dout_ready;
   assign out_last = out_hs && (idx_reg == LAST_SHARE);

   // The core is not advanced in a flush cycle: its contents are being
   // discarded anyway, and holding it keeps it quiet while the buffers clear.
   assign sbox_en = !flush && ena && (state_reg == S_RUN) && (cnt_reg < CNT_CAP);
   assign capture = !flush && ena && (state_reg == S_RUN) && (cnt_reg == CNT_CAP);

   assign buf_clr = flush || out_last;

   // dout is registered one share ahead: while share idx is on dout, the
   // bank's read port already presents share idx+1.
   assign rd_idx = idx_reg + 1'b1;

   assign busy = (state_reg != S_LOAD);
   assign done = done_reg;
   assign dout = dout_reg;

   ti_sbox_seq_buf #(
      .NSHARES   (NSHARES),
      .RND_BYTES (RND_BYTES),
      .IDX_W     (IDX_W)
   ) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (buf_clr),
      .wr_en   (in_hs),
      .wr_idx  (idx_reg),
      .wr_data (din),
      .ld_en   (capture),
      .ld_data (sbox_y),
      .rd_idx  (rd_idx),
      .rd_data (rd_data),
      .x_flat  (sbox_x),
      .r_flat  (sbox_r)
   );

   // ------------------------------------------------------------------
   // Sequencer FSM and counters.
   // idx never passes LAST_SLOT in LOAD or LAST_SHARE in UNLOAD, and cnt
   // never passes LATENCY, because each reaching its limit changes state.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_LOAD;
         idx_reg   <= '0;
         cnt_reg   <= '0;
         dout_reg  <= '0;
         done_reg  <= 1'b0;
      end else if (flush) begin
         state_reg <= S_LOAD;
         idx_reg   <= '0;
         cnt_reg   <= '0;
         dout_reg  <= '0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (ena) begin
            case (state_reg)
               S_LOAD: begin
                  if (in_hs) begin
                     if (idx_reg == LAST_SLOT) begin
                        state_reg <= S_RUN;
                        idx_reg   <= '0;
                        cnt_reg   <= '0;
                     end else begin
                        idx_reg <= idx_reg + 1'b1;
                     end
                  end
               end

               S_RUN: begin
                  if (cnt_reg < CNT_CAP) begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end else begin
                     // Capture cycle: the bank loads all of sbox_y on this
                     // edge; dout takes share 0 of the same value so it is
                     // valid in the first UNLOAD cycle.
                     state_reg <= S_UNLOAD;
                     idx_reg   <= '0;
                     cnt_reg   <= '0;
                     dout_reg  <= sbox_y[7:0];
                  end
               end

               S_UNLOAD: begin
                  if (out_hs) begin
                     if (idx_reg == LAST_SHARE) begin
                        state_reg <= S_LOAD;
                        idx_reg   <= '0;
                        dout_reg  <= '0;
                        done_reg  <= 1'b1;
                     end else begin
                        idx_reg  <= idx_reg + 1'b1;
                        dout_reg <= rd_data;
                     end
                  end
               end

               default: begin
                  state_reg <= S_LOAD;
                  idx_reg   <= '0;
                  cnt_reg   <= '0;
                  dout_reg  <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ti_sbox_seq.sv
// -----------------------------------------------------------------------------
// tb_ti_sbox_seq
// Bench for ti_sbox_seq with a behavioural 4-stage TI S-box core model.
// Each transaction pushes its expected output shares to a queue when the
// stimulus is built; output handshakes pop and compare them.
// -----------------------------------------------------------------------------
module tb_ti_sbox_seq;

   localparam int NS    = 3;
   localparam int RB    = 4;
   localparam int LAT   = 4;
   localparam int NSLOT = NS + RB;

   logic            clk;
   logic            rst_n;
   logic            ena;
   logic            flush;
   logic [7:0]      din;
   logic            din_valid;
   logic            din_ready;
   logic [7:0]      dout;
   logic            dout_valid;
   logic            dout_ready;
   logic [NS*8-1:0] sbox_x;
   logic [RB*8-1:0] sbox_r;
   logic            sbox_en;
   logic [NS*8-1:0] sbox_y;
   logic            busy;
   logic            done;

   ti_sbox_seq #(
      .NSHARES   (NS),
      .RND_BYTES (RB),
      .LATENCY   (LAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .flush      (flush),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .sbox_x     (sbox_x),
      .sbox_r     (sbox_r),
      .sbox_en    (sbox_en),
      .sbox_y     (sbox_y),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference AES S-box ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         b = {1'b0, b[7:1]};
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [7:0] aes_sbox(input logic [7:0] x);
      logic [7:0] res, base, b;
      res = 8'h01; base = x;
      // x^254 is the field inverse (and maps 0 to 0)
      for (int i = 0; i < 8; i++) begin
         if (i != 0) res = gmul(res, base);
         base = gmul(base, base);
      end
      b = res;
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   // Share mapping of the core model: two shares are pure randomness,
   // the third carries S(x) re-masked by them.
   function automatic logic [NS*8-1:0] core_f(input logic [NS*8-1:0] x, input logic [RB*8-1:0] r);
      logic [7:0] y0, y1, s;
      s  = aes_sbox(x[7:0] ^ x[15:8] ^ x[23:16]);
      y0 = r[7:0] ^ r[23:16];
      y1 = r[15:8] ^ r[31:24];
      return {s ^ y0 ^ y1, y1, y0};
   endfunction

   // ---------------- core pipeline model ----------------
   logic [NS*8-1:0] pipe [LAT];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LAT; k++) pipe[k] <= '0;
      end else if (sbox_en) begin
         pipe[0] <= core_f(sbox_x, sbox_r);
         for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
   end
   assign sbox_y = pipe[LAT-1];

   // ---------------- bookkeeping ----------------
   int tests = 0;
   int fails = 0;

   logic [7:0]      q_exp[$];
   logic [NS*8-1:0] cur_x;
   logic [RB*8-1:0] cur_r;
   logic [NS*8-1:0] got_bytes;
   logic [NS*8-1:0] got_hist [8];
   logic [7:0]      out_xor;
   int out_n, done_n, en_n, run_n, hold_bad, first_dv, done_cyc;
   bit in_hs_seen;

   typedef struct packed {
      logic [NS*8-1:0] x;
      logic [RB*8-1:0] r;
      logic [7:0]      y;   // expected XOR of the output shares
   } vec_t;
   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_stats();
      out_n = 0; done_n = 0; en_n = 0; run_n = 0; hold_bad = 0;
      first_dv = -1; done_cyc = -1; out_xor = 8'h00; got_bytes = '0;
   endtask

   // One clock cycle: drive at the falling edge, sample 1 time unit later.
   task automatic tick(input bit dv, input logic [7:0] d, input bit dr, input bit en, input bit fl);
      logic [7:0] e;
      @(negedge clk);
      din_valid = dv; din = d; dout_ready = dr; ena = en; flush = fl;
      #1;
      in_hs_seen = dv && din_ready && !fl;
      if (dout_valid && dr && !fl) begin
         chk("dout_queue_nonempty", 32'(q_exp.size() != 0), 32'd1);
         if (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            chk("dout_share", {24'h0, dout}, {24'h0, e});
         end
         out_xor = out_xor ^ dout;
         if (out_n < NS) got_bytes[out_n*8 +: 8] = dout;
         out_n++;
      end
      if (dout_valid && first_dv < 0) first_dv = cyc;
      if (done) begin
         done_n++;
         if (done_cyc < 0) done_cyc = cyc;
      end
      if (sbox_en) en_n++;
      if (busy && !dout_valid) run_n++;
      if (busy && !fl && (sbox_x !== cur_x || sbox_r !== cur_r)) hold_bad++;
   endtask

   task automatic setup_vec(input int vi);
      logic [NS*8-1:0] y;
      cur_x = vecs[vi].x;
      cur_r = vecs[vi].r;
      y = core_f(cur_x, cur_r);
      for (int s = 0; s < NS; s++) q_exp.push_back(y[s*8 +: 8]);
      clear_stats();
   endtask

   function automatic logic [7:0] slot_byte(input int ptr);
      if (ptr < NS) return cur_x[ptr*8 +: 8];
      return cur_r[(ptr-NS)*8 +: 8];
   endfunction

   task automatic finish_txn(input string tag, input logic [7:0] exp_xor);
      chk({tag, "_done_seen"}, 32'(done_n != 0), 32'd1);
      tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk({tag, "_done_once"}, done_n, 1);
      chk({tag, "_ready_after"}, {31'h0, din_ready}, 32'd1);
      chk({tag, "_out_count"}, out_n, NS);
      chk({tag, "_out_xor"}, {24'h0, out_xor}, {24'h0, exp_xor});
      chk({tag, "_hold"}, hold_bad, 0);
      chk({tag, "_queue_empty"}, q_exp.size(), 0);
      q_exp.delete();
   endtask

   task automatic run_txn(input int vi, input int pv, input int pr, input bit timed);
      int ptr, guard, t0;
      setup_vec(vi);
      ptr = 0; guard = 0; t0 = -1;
      while (done_n == 0 && guard < 400) begin
         tick(ptr < NSLOT && $urandom_range(99) < pv,
              (ptr < NSLOT) ? slot_byte(ptr) : 8'h00,
              $urandom_range(99) < pr, 1'b1, 1'b0);
         if (in_hs_seen) begin
            if (t0 < 0) t0 = cyc;
            ptr++;
         end
         guard++;
      end
      chk("txn_en_cycles", en_n, LAT);
      if (timed) begin
         chk("txn_first_dout_latency", first_dv - t0, 12);
         chk("txn_total_cycles", done_cyc - t0, 15);
      end
      got_hist[vi] = got_bytes;
      finish_txn("txn", vecs[vi].y);
      $display("[TB] txn vec=%0d x=%h r=%h shares=%h xor=%h", vi, cur_x, cur_r, got_hist[vi], out_xor);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_din_ready"},  {31'h0, din_ready},  32'd1);
      chk({tag, "_dout"},       {24'h0, dout},       32'd0);
      chk({tag, "_dout_valid"}, {31'h0, dout_valid}, 32'd0);
      chk({tag, "_sbox_x"},     {8'h0, sbox_x},      32'd0);
      chk({tag, "_sbox_r"},     sbox_r,              32'd0);
      chk({tag, "_sbox_en"},    {31'h0, sbox_en},    32'd0);
      chk({tag, "_busy"},       {31'h0, busy},       32'd0);
      chk({tag, "_done"},       {31'h0, done},       32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      vecs[0] = '{x: 24'h753412, r: 32'h00000000, y: 8'hED};
      vecs[1] = '{x: 24'h753412, r: 32'hF00F3CA5, y: 8'hED};
      vecs[2] = '{x: 24'h000000, r: 32'h00000000, y: 8'h63};
      vecs[3] = '{x: 24'h000053, r: 32'h44332211, y: 8'hED};
      vecs[4] = '{x: 24'h000001, r: 32'h9F3B7E5A, y: 8'h7C};
      vecs[5] = '{x: 24'h00F00F, r: 32'hEFBEADDE, y: 8'h16};
      vecs[6] = '{x: 24'h019A9A, r: 32'h04030201, y: 8'h7C};

      rst_n = 1'b0; ena = 1'b1; flush = 1'b0;
      din = 8'h00; din_valid = 1'b0; dout_ready = 1'b0;
      cur_x = '0; cur_r = '0;
      clear_stats();

      // Reset state
      @(negedge clk); #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Continuous traffic, with and without randomness
      run_txn(0, 100, 100, 1'b1);
      run_txn(1, 100, 100, 1'b1);
      chk("rnd_changes_shares", 32'(got_hist[0] != got_hist[1]), 32'd1);

      // Random 50% valid/ready
      for (int vi = 3; vi < 7; vi++) run_txn(vi, 50, 50, 1'b0);

      // ena stall for 3 cycles at RUN cnt=2
      setup_vec(0);
      for (int s = 0; s < NSLOT; s++) tick(1'b1, slot_byte(s), 1'b0, 1'b1, 1'b0);
      tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("stall_en_cnt0", {31'h0, sbox_en}, 32'd1);
      tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("stall_en_cnt1", {31'h0, sbox_en}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
         chk("stall_en_frozen", {31'h0, sbox_en}, 32'd0);
         chk("stall_ready_masked", {30'h0, din_ready, dout_valid}, 32'd0);
      end
      guard = 0;
      while (done_n == 0 && guard < 50) begin
         tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
         guard++;
      end
      chk("stall_run_len", run_n, 8);
      chk("stall_en_cycles", en_n, LAT);
      finish_txn("stall", 8'hED);
      $display("[TB] txn stall run_len=%0d en=%0d xor=%h", run_n, en_n, out_xor);

      // Flush after the second output handshake
      setup_vec(1);
      for (int s = 0; s < NSLOT; s++) tick(1'b1, slot_byte(s), 1'b0, 1'b1, 1'b0);
      guard = 0;
      while (out_n < 2 && guard < 50) begin
         tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
         guard++;
      end
      chk("flush_reached_share2", out_n, 2);
      tick(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("flush_busy",      {31'h0, busy},      32'd0);
      chk("flush_din_ready", {31'h0, din_ready}, 32'd1);
      chk("flush_dout",      {24'h0, dout},      32'd0);
      chk("flush_sbox_x",    {8'h0, sbox_x},     32'd0);
      chk("flush_sbox_r",    sbox_r,             32'd0);
      tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("flush_no_done", done_n, 0);
      chk("flush_out_count", out_n, 2);
      $display("[TB] txn flush after %0d outputs", out_n);
      q_exp.delete();
      run_txn(2, 100, 100, 1'b1);

      // Asynchronous reset mid-LOAD at idx=5
      setup_vec(5);
      for (int s = 0; s < 5; s++) tick(1'b1, slot_byte(s), 1'b0, 1'b1, 1'b0);
      @(posedge clk); #2;
      din_valid = 1'b0;
      chk("preload_sbox_x", {8'h0, sbox_x}, {8'h0, cur_x});
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      $display("[TB] txn reset mid-load");
      q_exp.delete();
      @(negedge clk);
      rst_n = 1'b1;
      run_txn(6, 100, 100, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
